// File: rtl/rca_slice_sequencer.sv
// rtl/rca_slice_sequencer.sv - sliced wide adder over one 4-bit ripple_carry_adder; optional SIGNED_OVF_EN adds ovf port

// 4-bit ripple-carry adder built from bit-level full adders
module ripple_carry_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[4];

endmodule

module rca_slice_sequencer #(
  parameter int NSLICES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NSLICES-1:0] a,
  input  logic [4*NSLICES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NSLICES-1:0] sum,
`ifdef SIGNED_OVF_EN
  output logic                 ovf,
`endif
  output logic                 cout
);

  localparam int W  = 4 * NSLICES;
  localparam int IW = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICES - 1);

  typedef enum logic [1:0] {st_idle, st_run, st_done} state_t;

  state_t        state, state_next;
  logic [W-1:0]  a_r, b_r;
  logic [IW-1:0] idx;
  logic          carry_r;
  logic [3:0]    a_s, b_s, sum_s;
  logic          cout_s;
  logic          last_slice;
  logic          accept;

  assign a_s        = a_r[4*idx +: 4];
  assign b_s        = b_r[4*idx +: 4];
  assign last_slice = (idx == LAST_IDX);
  assign accept     = (state == st_idle) && in_valid;

  ripple_carry_adder u_rca (
    .a    (a_s),
    .b    (b_s),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= st_idle;
    else        state <= state_next;
  end

  // Next-state and handshake outputs; accept and complete never overlap
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      st_idle: begin
        in_ready = 1'b1;
        if (in_valid) state_next = st_run;
      end
      st_run: begin
        if (last_slice) state_next = st_done;
      end
      st_done: begin
        out_valid = 1'b1;
        if (out_ready) state_next = st_idle;
      end
      default: state_next = st_idle;
    endcase
  end

  // Operand capture, per-slice sum write-back and inter-slice carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      idx     <= '0;
      carry_r <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b;
      idx     <= '0;
      carry_r <= cin;
      sum     <= '0;
      cout    <= 1'b0;
    end else if (state == st_run) begin
      sum[4*idx +: 4] <= sum_s;
      carry_r         <= cout_s;
      idx             <= last_slice ? '0 : idx + IW'(1);
      if (last_slice) cout <= cout_s;
    end
  end

`ifdef SIGNED_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (accept)
      ovf <= 1'b0;
    else if (state == st_run && last_slice)
      ovf <= (a_r[W-1] ^ b_r[W-1] ^ sum_s[3]) ^ cout_s;
  end
`endif

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// tb/tb_rca_slice_sequencer.sv - directed-vector bench for rca_slice_sequencer (NSLICES=4)

module tb_rca_slice_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef SIGNED_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  rca_slice_sequencer #(.NSLICES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SIGNED_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation: present operands in IDLE, measure latency, check result,
  // then release via out_ready (already high when early=1).
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic [15:0] esum, input logic ecout,
                        input bit early);
    int cnt;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    cin       = tc;
    out_ready = early;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'hdead;
    b        = 16'hbeef;
    cin      = 1'b1;
    check({tag, "_busy_ready"}, in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, cnt, 4);
    check({tag, "_sum"}, sum, esum);
    check({tag, "_cout"}, cout, ecout);
    check({tag, "_no_bypass"}, in_ready, 0);
`ifdef SIGNED_OVF_EN
    check({tag, "_ovf"}, ovf, (ta[15] == tb_v[15]) && (esum[15] != ta[15]));
`endif
    if (!early) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, out_valid, 1);
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_done_valid"}, out_valid, 0);
    check({tag, "_done_ready"}, in_ready, 1);
    check({tag, "_retained"}, sum, esum);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    @(negedge clk);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0);
    run_op("slice_carry", 16'h00ff, 16'h0001, 1'b0, 16'h0100, 1'b0, 1);
    run_op("all_ones", 16'hffff, 16'hffff, 1'b1, 16'hffff, 1'b1, 0);
    run_op("wrap", 16'hffff, 16'h0000, 1'b1, 16'h0000, 1'b1, 0);

    // Backpressure: result held 5 cycles, new in_valid ignored
    in_valid = 1'b1;
    a        = 16'h1234;
    b        = 16'h4321;
    cin      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 16'h1111;
    b = 16'h1111;
    for (int i = 0; i < 4; i++) @(negedge clk);
    check("bp_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_sum", sum, 16'h5555);
      check("bp_hold_ready", in_ready, 0);
    end
    check("bp_cout", cout, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    check("bp_sum_kept", sum, 16'h5555);

    // Reset in the middle of RUN
    in_valid = 1'b1;
    a        = 16'h0f0f;
    b        = 16'h0f0f;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_stale", seen, 0);
    check("abort_sum_after", sum, 0);

`ifdef SIGNED_OVF_EN
    run_op("ovf_pos", 16'h7fff, 16'h0001, 1'b0, 16'h8000, 1'b0, 0);
    run_op("ovf_neg", 16'h8000, 16'hffff, 1'b0, 16'h7fff, 1'b1, 0);
    run_op("ovf_none", 16'h0003, 16'hfffe, 1'b0, 16'h0001, 1'b1, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
